// File: rtl/miriscv_pkg.sv
// Shared core-wide types and widths for the miriscv pipeline.
// fetch_entry_t is one fetched instruction as it travels from fetch to decode.
package miriscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [ILEN-1:0] instr;
    logic            err;
  } fetch_entry_t;

endpackage

// File: rtl/miriscv_fetch_decode_buffer_if.sv
// Fetch/decode handshake bundle. master = fetch + decode + control side,
// slave = the buffer itself.
//
// Handshake: a transfer happens on a rising clk_i edge when valid and ready are
// both 1 in that cycle. A source holding valid may change its payload only
// after the transfer. Ready never depends combinationally on valid in this
// block. cu_kill_i cancels both the fetch-side and decode-side transfers of its
// cycle.
interface miriscv_fetch_decode_buffer_if
  import miriscv_pkg::*;
#(
  parameter int XLEN  = miriscv_pkg::XLEN,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             f_valid_i;
  logic [XLEN-1:0]  f_pc_i;
  logic [XLEN-1:0]  f_pc_next_i;
  logic [31:0]      f_instr_i;
  logic             f_err_i;
  logic             f_ready_o;
  logic             cu_kill_i;
  logic             d_valid_o;
  logic [XLEN-1:0]  d_pc_o;
  logic [XLEN-1:0]  d_pc_next_o;
  logic [31:0]      d_instr_o;
  logic             d_err_o;
  logic             d_ready_i;
  logic [CNT_W-1:0] count_o;

  modport master (
    output f_valid_i, f_pc_i, f_pc_next_i, f_instr_i, f_err_i,
    output cu_kill_i, d_ready_i,
    input  f_ready_o, d_valid_o, d_pc_o, d_pc_next_o, d_instr_o, d_err_o,
    input  count_o
  );

  modport slave (
    input  f_valid_i, f_pc_i, f_pc_next_i, f_instr_i, f_err_i,
    input  cu_kill_i, d_ready_i,
    output f_ready_o, d_valid_o, d_pc_o, d_pc_next_o, d_instr_o, d_err_o,
    output count_o
  );

endinterface

// File: rtl/miriscv_sync_fifo.sv
// Generic synchronous FIFO: circular storage with naturally wrapping pointers
// and an occupancy counter. The caller must not push when full or pop when empty.
module miriscv_sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  // DEPTH is a power of two, so pointer overflow is exactly the modulo wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage has no reset; a stale entry is never visible because empty masks it.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

`ifndef SYNTHESIS
  a_depth_pow2: assert property (@(posedge clk_i)
    (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop && empty));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: rtl/miriscv_fetch_decode_buffer.sv
// Instruction queue between fetch and decode. Entries leave in push order;
// a control-unit kill empties the queue and cancels that cycle's push and pop.
module miriscv_fetch_decode_buffer
  import miriscv_pkg::*;
#(
  parameter int  XLEN  = miriscv_pkg::XLEN,
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  miriscv_fetch_decode_buffer_if.slave  bus
);

  fetch_entry_t     wr_entry;
  fetch_entry_t     rd_entry;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;

  // Ready comes from registered occupancy only, so decode stalls never reach
  // fetch through combinational logic.
  assign bus.f_ready_o = ~full;
  assign bus.d_valid_o = ~empty;

  assign push = bus.f_valid_i & ~full  & ~bus.cu_kill_i;
  assign pop  = bus.d_ready_i & ~empty & ~bus.cu_kill_i;

  always_comb begin
    wr_entry         = '0;
    wr_entry.pc      = bus.f_pc_i;
    wr_entry.pc_next = bus.f_pc_next_i;
    wr_entry.instr   = bus.f_instr_i;
    wr_entry.err     = bus.f_err_i;
  end

  miriscv_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (bus.cu_kill_i),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Bus errors ride along as ordinary entries; decode turns them into traps.
  assign bus.d_pc_o      = rd_entry.pc;
  assign bus.d_pc_next_o = rd_entry.pc_next;
  assign bus.d_instr_o   = rd_entry.instr;
  assign bus.d_err_o     = rd_entry.err;
  assign bus.count_o     = count;

`ifndef SYNTHESIS
  a_xlen_match: assert property (@(posedge clk_i) XLEN == miriscv_pkg::XLEN);
`endif

endmodule

// File: tb/tb_miriscv_fetch_decode_buffer.sv
// Bench for the fetch/decode buffer: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_miriscv_fetch_decode_buffer;
  import miriscv_pkg::*;

  localparam int DEPTH = 2;
  localparam int EW    = $bits(fetch_entry_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  miriscv_fetch_decode_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  miriscv_fetch_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic          obs_err[$];
  logic          last_push;
  int            n_pass  = 0;
  int            n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_model();
    fetch_entry_t h;
    chk("count",   64'(bus.count_o),   64'(exp_q.size()));
    chk("f_ready", 64'(bus.f_ready_o), 64'(exp_q.size() < DEPTH));
    chk("d_valid", 64'(bus.d_valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      h = fetch_entry_t'(exp_q[0]);
      chk("d_pc",      64'(bus.d_pc_o),      64'(h.pc));
      chk("d_pc_next", 64'(bus.d_pc_next_o), 64'(h.pc_next));
      chk("d_instr",   64'(bus.d_instr_o),   64'(h.instr));
      chk("d_err",     64'(bus.d_err_o),     64'(h.err));
    end
  endtask

  // driver: one clock cycle of inputs, then model update and check
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic e, input logic rdy, input logic kill, input logic r);
    logic         m_push;
    logic         m_pop;
    fetch_entry_t ent;
    bus.f_valid_i   = v;
    bus.f_pc_i      = pc;
    bus.f_pc_next_i = pc + 32'd4;
    bus.f_instr_i   = instr;
    bus.f_err_i     = e;
    bus.d_ready_i   = rdy;
    bus.cu_kill_i   = kill;
    rst             = r;
    m_push = v && (exp_q.size() < DEPTH) && !kill && !r;
    m_pop  = rdy && (exp_q.size() != 0) && !kill && !r;
    ent = '{pc: pc, pc_next: pc + 32'd4, instr: instr, err: e};
    #1;
    if (m_pop) obs_err.push_back(bus.d_err_o);
    @(posedge clk);
    #1;
    if (r || kill) begin
      exp_q.delete();
    end else begin
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(EW'(ent));
    end
    last_push = m_push;
    check_model();
  endtask

  initial begin
    logic [4:0] pat;
    logic       tog;
    int         tries;

    // 1: reset then single push
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 64'(bus.d_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.f_ready_o), 64'd1);
    chk("rst_count", 64'(bus.count_o),   64'd0);
    cyc(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid",   64'(bus.d_valid_o),   64'd1);
    chk("t1_pc",      64'(bus.d_pc_o),      64'h8000_0000);
    chk("t1_pc_next", 64'(bus.d_pc_next_o), 64'h8000_0004);
    chk("t1_instr",   64'(bus.d_instr_o),   64'h0000_0013);
    chk("t1_err",     64'(bus.d_err_o),     64'd0);
    chk("t1_count",   64'(bus.count_o),     64'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 2: fill, blocked third push, then drain
    cyc(1'b1, 32'h100, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h104, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_count", 64'(bus.count_o),   64'd2);
    chk("t2_ready", 64'(bus.f_ready_o), 64'd0);
    cyc(1'b1, 32'h108, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_blocked", 64'(bus.count_o), 64'd2);
    chk("t2_head0",   64'(bus.d_pc_o),  64'h100);
    cyc(1'b1, 32'h108, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_head1",   64'(bus.d_pc_o),    64'h104);
    chk("t2_reopen",  64'(bus.f_ready_o), 64'd1);
    cyc(1'b1, 32'h108, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_head2",   64'(bus.d_pc_o),  64'h108);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_empty",   64'(bus.count_o), 64'd0);

    // 3: streaming push/pop at count 1
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h200 + 32'(4 * i), $urandom(), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_head",  64'(bus.d_pc_o),  64'(32'h200 + 32'(4 * i)));
      chk("t3_count", 64'(bus.count_o), 64'd1);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 4: kill with concurrent push
    cyc(1'b1, 32'h300, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h304, 32'h31, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h308, 32'h32, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_count", 64'(bus.count_o),   64'd0);
    chk("t4_valid", 64'(bus.d_valid_o), 64'd0);
    cyc(1'b1, 32'h400, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_head",  64'(bus.d_pc_o),    64'h400);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: error flags across pointer wrap, decode ready toggling
    obs_err.delete();
    pat = 5'b11010;
    tog = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tries = 0;
      do begin
        cyc(1'b1, 32'h500 + 32'(4 * i), $urandom(), pat[i], tog, 1'b0, 1'b0);
        tog = ~tog;
        tries++;
      end while (!last_push && tries < 8);
      chk("t5_accept", 64'(last_push), 64'd1);
    end
    repeat (4) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_npop", 64'(obs_err.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs_err.size()) chk("t5_err_seq", 64'(obs_err[i]), 64'(pat[i]));
    end

    // 6: reset mid-operation with decode ready
    cyc(1'b1, 32'h600, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h604, 32'h61, 1'b0, 1'b0, 1'b0, 1'b0);
    obs_err.delete();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_valid", 64'(bus.d_valid_o), 64'd0);
    chk("t6_ready", 64'(bus.f_ready_o), 64'd1);
    chk("t6_count", 64'(bus.count_o),   64'd0);
    chk("t6_nopop", 64'(obs_err.size()), 64'd0);
    cyc(1'b1, 32'h700, 32'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_head",  64'(bus.d_pc_o),    64'h700);

    // random traffic with occasional kill and reset
    repeat (400) begin
      cyc(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
